// File: rtl/buzzer_arbiter_pkg.sv
// Shared definitions for the buzzer arbiter: sequencer states and GRANT encodings.
package buzzer_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP,
    ST_CHIME,
    ST_ALM_ON,
    ST_ALM_OFF
  } state_t;

  localparam logic [2:0] GNT_NONE  = 3'b000;
  localparam logic [2:0] GNT_ALARM = 3'b100;
  localparam logic [2:0] GNT_CHIME = 3'b010;
  localparam logic [2:0] GNT_BEEP  = 3'b001;

  function automatic logic [2:0] grant_of(state_t s);
    case (s)
      ST_BEEP:              return GNT_BEEP;
      ST_CHIME:             return GNT_CHIME;
      ST_ALM_ON, ST_ALM_OFF: return GNT_ALARM;
      default:              return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_arbiter_if.sv
// Request and drive signals between the clock controllers and the buzzer arbiter.
interface buzzer_arbiter_if;
  logic       MS_TICK;
  logic       ALARM_REQ;
  logic       CHIME_REQ;
  logic       BEEP_REQ;
  logic       STOP;
  logic       PIEZO;
  logic [2:0] GRANT;
  logic       ALARM_DONE;

  modport master (
    output MS_TICK, ALARM_REQ, CHIME_REQ, BEEP_REQ, STOP,
    input  PIEZO, GRANT, ALARM_DONE
  );

  modport slave (
    input  MS_TICK, ALARM_REQ, CHIME_REQ, BEEP_REQ, STOP,
    output PIEZO, GRANT, ALARM_DONE
  );
endinterface

// File: rtl/buzzer_arbiter_tone_gen.sv
// Square-wave generator: toggles PIEZO every HALF cycles while enabled.
module tone_gen (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        EN,
  input  logic        RESTART,
  input  logic [15:0] HALF,
  output logic        PIEZO
);

  logic [15:0] r_cnt;
  logic        r_piezo;

  always_ff @(posedge CLK) begin
    if (!RESETN || !EN || RESTART) begin
      r_cnt   <= '0;
      r_piezo <= 1'b0;
    end else if (r_cnt == HALF - 16'd1) begin
      r_cnt   <= '0;
      r_piezo <= ~r_piezo;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign PIEZO = r_piezo;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority owner of the piezo: alarm > chime > beep, with preemption,
// cadence sequencing and auto-silence of an alarm left ringing.
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int HALF_ALARM   = 25000,
  parameter int HALF_CHIME   = 18750,
  parameter int HALF_BEEP    = 12500,
  parameter int BEEP_MS      = 50,
  parameter int CHIME_MS     = 300,
  parameter int CADENCE_MS   = 500,
  parameter int ALARM_BURSTS = 60
) (
  input logic             CLK,
  input logic             RESETN,
  buzzer_arbiter_if.slave bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_grant;
  logic        r_alarm_req;
  logic        r_alarm_done;
  logic        r_chime_pend;
  logic        r_beep_pend;
  logic [15:0] r_dur_cnt;
  logic [15:0] r_burst_cnt;

  logic        w_elig;
  logic        w_dur_end;
  logic        w_burst_end;
  logic        w_enter;
  logic        w_in_alarm;
  logic        w_to_alarm;
  logic        w_set_done;
  logic        w_tone_en;
  logic [15:0] w_dur_len;
  logic [15:0] w_half;
  logic        w_piezo;

  // ALARM_REQ is sampled first so every request reaches GRANT one edge after it is seen.
  assign w_elig      = r_alarm_req && !r_alarm_done;
  assign w_in_alarm  = (r_state == ST_ALM_ON) || (r_state == ST_ALM_OFF);
  assign w_to_alarm  = (w_next_state == ST_ALM_ON) || (w_next_state == ST_ALM_OFF);
  assign w_enter     = (w_next_state != r_state);
  assign w_dur_end   = bus.MS_TICK && (r_dur_cnt == w_dur_len - 16'd1);
  assign w_burst_end = (r_burst_cnt == 16'(ALARM_BURSTS - 1));
  assign w_set_done  = r_alarm_req && w_in_alarm &&
                       (bus.STOP || (r_state == ST_ALM_OFF && w_dur_end && w_burst_end));

  always_comb begin
    w_dur_len = 16'd0;
    case (r_state)
      ST_BEEP:               w_dur_len = 16'(BEEP_MS);
      ST_CHIME:              w_dur_len = 16'(CHIME_MS);
      ST_ALM_ON, ST_ALM_OFF: w_dur_len = 16'(CADENCE_MS);
      default:               w_dur_len = 16'd0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:
        if (w_elig)            w_next_state = ST_ALM_ON;
        else if (r_chime_pend) w_next_state = ST_CHIME;
        else if (r_beep_pend)  w_next_state = ST_BEEP;
      ST_BEEP:
        if (w_elig)            w_next_state = ST_ALM_ON;
        else if (r_chime_pend) w_next_state = ST_CHIME;
        else if (w_dur_end)    w_next_state = ST_IDLE;
      ST_CHIME:
        if (w_elig)            w_next_state = ST_ALM_ON;
        else if (w_dur_end)    w_next_state = ST_IDLE;
      ST_ALM_ON:
        if (!r_alarm_req || bus.STOP) w_next_state = ST_IDLE;
        else if (w_dur_end)           w_next_state = ST_ALM_OFF;
      ST_ALM_OFF:
        if (!r_alarm_req || bus.STOP) w_next_state = ST_IDLE;
        else if (w_dur_end)           w_next_state = w_burst_end ? ST_IDLE : ST_ALM_ON;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // A pending bit cleared on entry still captures a fresh request on that same edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_NONE;
      r_alarm_req  <= 1'b0;
      r_alarm_done <= 1'b0;
      r_chime_pend <= 1'b0;
      r_beep_pend  <= 1'b0;
      r_dur_cnt    <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_grant     <= grant_of(w_next_state);
      r_alarm_req <= bus.ALARM_REQ;

      if (!r_alarm_req)    r_alarm_done <= 1'b0;
      else if (w_set_done) r_alarm_done <= 1'b1;

      if (w_enter)          r_dur_cnt <= '0;
      else if (bus.MS_TICK) r_dur_cnt <= r_dur_cnt + 16'd1;

      if (w_next_state == ST_ALM_ON && !w_in_alarm)
        r_burst_cnt <= '0;
      else if (r_state == ST_ALM_OFF && w_next_state == ST_ALM_ON)
        r_burst_cnt <= r_burst_cnt + 16'd1;

      if (w_enter && w_next_state == ST_CHIME) r_chime_pend <= bus.CHIME_REQ;
      else                                     r_chime_pend <= r_chime_pend | bus.CHIME_REQ;

      if (w_in_alarm || w_to_alarm)               r_beep_pend <= 1'b0;
      else if (w_enter && w_next_state == ST_BEEP) r_beep_pend <= bus.BEEP_REQ;
      else                                        r_beep_pend <= r_beep_pend | bus.BEEP_REQ;
    end
  end

  always_comb begin
    w_tone_en = 1'b1;
    w_half    = 16'd1;
    case (w_next_state)
      ST_BEEP:   w_half = 16'(HALF_BEEP);
      ST_CHIME:  w_half = 16'(HALF_CHIME);
      ST_ALM_ON: w_half = 16'(HALF_ALARM);
      default:   w_tone_en = 1'b0;
    endcase
  end

  tone_gen u_tone (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .EN      (w_tone_en),
    .RESTART (w_enter),
    .HALF    (w_half),
    .PIEZO   (w_piezo)
  );

  assign bus.PIEZO      = w_piezo;
  assign bus.GRANT      = r_grant;
  assign bus.ALARM_DONE = r_alarm_done;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Randomised scoreboard bench for buzzer_arbiter against a sound-level reference model.
module tb_buzzer_arbiter;
  import buzzer_arbiter_pkg::*;

  localparam int HALF_ALARM   = 5;
  localparam int HALF_CHIME   = 4;
  localparam int HALF_BEEP    = 3;
  localparam int BEEP_MS      = 3;
  localparam int CHIME_MS     = 5;
  localparam int CADENCE_MS   = 4;
  localparam int ALARM_BURSTS = 3;
  localparam int TICK_PERIOD  = 16;

  localparam int SND_IDLE  = 0;
  localparam int SND_BEEP  = 1;
  localparam int SND_CHIME = 2;
  localparam int SND_ALARM = 3;

  typedef struct packed {
    logic [2:0] grant;
    logic       piezo;
    logic       done;
  } expect_t;

  logic CLK = 1'b0;
  logic RESETN;
  buzzer_arbiter_if bus ();

  buzzer_arbiter #(
    .HALF_ALARM   (HALF_ALARM),
    .HALF_CHIME   (HALF_CHIME),
    .HALF_BEEP    (HALF_BEEP),
    .BEEP_MS      (BEEP_MS),
    .CHIME_MS     (CHIME_MS),
    .CADENCE_MS   (CADENCE_MS),
    .ALARM_BURSTS (ALARM_BURSTS)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  expect_t expQ[$];
  int checks   = 0;
  int failures = 0;

  int snd        = SND_IDLE;
  bit almOn      = 0;
  int ticksLeft  = 0;
  int bursts     = 0;
  int cyc        = 0;
  bit alarmSeen  = 0;
  bit doneM      = 0;
  bit chimeWait  = 0;
  bit beepWait   = 0;

  task automatic finishRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, actual, expected);
      if (failures >= 40) finishRun();
    end
  endtask

  function automatic int lengthOf(int s);
    if (s == SND_BEEP)  return BEEP_MS;
    if (s == SND_CHIME) return CHIME_MS;
    if (s == SND_ALARM) return CADENCE_MS;
    return 0;
  endfunction

  function automatic int halfOf(int s);
    if (s == SND_BEEP)  return HALF_BEEP;
    if (s == SND_CHIME) return HALF_CHIME;
    return HALF_ALARM;
  endfunction

  // Sound-level reference: who owns the buzzer, ticks left, bursts played, cycles since start.
  task automatic modelStep();
    expect_t e;
    int  nextSnd;
    bit  nextOn, changed, setDone, elig, sounding;
    bit  tick, creq, breq, stp;
    if (!RESETN) begin
      snd = SND_IDLE; almOn = 0; ticksLeft = 0; bursts = 0; cyc = 0;
      alarmSeen = 0; doneM = 0; chimeWait = 0; beepWait = 0;
    end else begin
      tick = bus.MS_TICK; creq = bus.CHIME_REQ; breq = bus.BEEP_REQ; stp = bus.STOP;
      elig = alarmSeen && !doneM;
      nextSnd = snd; nextOn = almOn; setDone = 0;
      if (snd == SND_ALARM) begin
        if (!alarmSeen) nextSnd = SND_IDLE;
        else if (stp) begin nextSnd = SND_IDLE; setDone = 1; end
        else if (tick && ticksLeft == 1) begin
          if (almOn) nextOn = 0;
          else if (bursts + 1 == ALARM_BURSTS) begin nextSnd = SND_IDLE; setDone = 1; end
          else begin nextOn = 1; bursts++; end
        end
      end else if (elig) begin
        nextSnd = SND_ALARM; nextOn = 1; bursts = 0;
      end else if (snd == SND_IDLE) begin
        if (chimeWait)     nextSnd = SND_CHIME;
        else if (beepWait) nextSnd = SND_BEEP;
      end else if (snd == SND_BEEP && chimeWait) begin
        nextSnd = SND_CHIME;
      end else if (tick && ticksLeft == 1) begin
        nextSnd = SND_IDLE;
      end
      changed = (nextSnd != snd) || (nextSnd == SND_ALARM && nextOn != almOn);
      if (changed) begin
        ticksLeft = lengthOf(nextSnd);
        cyc = 0;
      end else begin
        if (tick && ticksLeft > 0) ticksLeft--;
        cyc++;
      end
      chimeWait = (changed && nextSnd == SND_CHIME) ? creq : (chimeWait | creq);
      if (snd == SND_ALARM || nextSnd == SND_ALARM) beepWait = 0;
      else beepWait = (changed && nextSnd == SND_BEEP) ? breq : (beepWait | breq);
      if (!alarmSeen)   doneM = 0;
      else if (setDone) doneM = 1;
      alarmSeen = bus.ALARM_REQ;
      snd = nextSnd;
      almOn = nextOn;
    end
    e.grant = (snd == SND_ALARM) ? 3'b100 : (snd == SND_CHIME) ? 3'b010 :
              (snd == SND_BEEP)  ? 3'b001 : 3'b000;
    sounding = (snd == SND_BEEP) || (snd == SND_CHIME) || (snd == SND_ALARM && almOn);
    e.piezo = sounding ? (((cyc / halfOf(snd)) % 2) == 1) : 1'b0;
    e.done  = doneM;
    expQ.push_back(e);
  endtask

  initial forever begin
    @(posedge CLK);
    modelStep();
  end

  initial begin
    expect_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("grant", bus.GRANT, e.grant);
        checkOutput("piezo", {2'b00, bus.PIEZO}, {2'b00, e.piezo});
        checkOutput("alarm_done", {2'b00, bus.ALARM_DONE}, {2'b00, e.done});
      end
    end
  end

  initial begin
    int tickCnt = 0;
    bus.MS_TICK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.MS_TICK = (tickCnt == TICK_PERIOD - 1);
      tickCnt = (tickCnt + 1) % TICK_PERIOD;
    end
  end

  // Drive levels/pulses one cycle, then idle for hold cycles; always called at posedge+1.
  task automatic applyStimulus(input bit alarm, input bit chime, input bit beep, input bit stp, input int hold);
    bus.ALARM_REQ = alarm;
    bus.CHIME_REQ = chime;
    bus.BEEP_REQ  = beep;
    bus.STOP      = stp;
    @(posedge CLK); #1;
    bus.CHIME_REQ = 1'b0;
    bus.BEEP_REQ  = 1'b0;
    bus.STOP      = 1'b0;
    repeat (hold) begin @(posedge CLK); #1; end
  endtask

  initial begin
    bit alarmLvl;
    RESETN = 1'b0;
    bus.ALARM_REQ = 1'b0; bus.CHIME_REQ = 1'b0; bus.BEEP_REQ = 1'b0; bus.STOP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b1;

    $display("[TB] beep from idle");
    applyStimulus(0, 0, 1, 0, 70);

    $display("[TB] beep queued behind chime");
    applyStimulus(0, 1, 0, 0, 20);
    applyStimulus(0, 0, 1, 0, 160);

    $display("[TB] alarm preempts chime, chime not replayed");
    applyStimulus(0, 1, 0, 0, 30);
    applyStimulus(1, 0, 0, 0, 100);
    applyStimulus(0, 0, 0, 0, 60);

    $display("[TB] alarm auto-silence");
    applyStimulus(1, 0, 0, 0, 440);
    applyStimulus(0, 0, 0, 0, 10);

    $display("[TB] stop during alarm, beep discarded");
    applyStimulus(1, 0, 0, 0, 10);
    applyStimulus(1, 0, 1, 0, 10);
    applyStimulus(1, 0, 0, 1, 30);
    applyStimulus(0, 0, 0, 0, 60);

    $display("[TB] reset during alarm");
    applyStimulus(1, 0, 0, 0, 25);
    RESETN = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    applyStimulus(1, 0, 0, 0, 150);
    applyStimulus(0, 0, 0, 0, 10);

    $display("[TB] randomised traffic");
    alarmLvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) alarmLvl = ~alarmLvl;
      if ($urandom_range(0, 1499) == 0) RESETN = 1'b0;
      else RESETN = 1'b1;
      applyStimulus(alarmLvl, $urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 199) == 0, 0);
    end
    RESETN = 1'b1;
    applyStimulus(0, 0, 0, 0, 100);

    @(negedge CLK); #1;
    finishRun();
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Shares the single piezo buzzer among the alarm ring, the hourly chime and the key-acknowledge beep, and sequences each sound's tone, cadence and duration. Sits between the key/mode controller and alarm comparator on one side and the piezo output pin on the other. Holds one sound at a time under fixed priority with preemption, and auto-silences a stuck alarm.

## Interface
Parameters:
- HALF_ALARM, 25000: tone half-period in CLK cycles for the alarm.
- HALF_CHIME, 18750: tone half-period for the chime.
- HALF_BEEP, 12500: tone half-period for the beep.
- BEEP_MS, 50: beep length in MS_TICK pulses.
- CHIME_MS, 300: chime length in MS_TICK pulses.
- CADENCE_MS, 500: alarm on-phase and off-phase length.
- ALARM_BURSTS, 60: alarm on/off pairs before auto-silence.

Ports:
- CLK  in  1  clock.
- RESETN  in  1  reset, synchronous, active-low; clock CLK.
- MS_TICK  in  1  one-CLK pulse every 1 ms.
- ALARM_REQ  in  1  level; alarm time matched and ALARM_ENABLE set.
- CHIME_REQ  in  1  one-CLK pulse at the top of each hour.
- BEEP_REQ  in  1  one-CLK pulse per accepted key press.
- STOP  in  1  one-CLK pulse; user silences the alarm.
- PIEZO  out  1  square-wave drive, low when silent.
- GRANT  out  3  one-hot {alarm, chime, beep}; 000 when idle.
- ALARM_DONE  out  1  alarm silenced (STOP or timeout) while ALARM_REQ is still high.

## Operation
- States: IDLE, BEEP, CHIME, ALM_ON, ALM_OFF.
- Priority: alarm > chime > beep. A higher request preempts the current sound on the next CLK.
- Pending latches: CHIME_REQ sets chime_pend and BEEP_REQ sets beep_pend. Each pending bit clears when its state is entered. beep_pend also clears whenever the alarm is granted, so beeps during an alarm are discarded. A preempted chime is not restarted.
- Alarm eligibility: ALARM_REQ=1 and ALARM_DONE=0.
- IDLE: if alarm eligible, go to ALM_ON. Else if chime_pend, go to CHIME. Else if beep_pend, go to BEEP.
- BEEP and CHIME: run for BEEP_MS or CHIME_MS MS_TICK pulses, then return to IDLE. Back-to-back pending requests are served in priority order.
- ALM_ON and ALM_OFF: alternate every CADENCE_MS ticks. burst_cnt increments on each ALM_OFF to ALM_ON transition.
- Alarm termination, all three cases go to IDLE:
  - STOP: sets ALARM_DONE.
  - burst_cnt reaches ALARM_BURSTS at the end of an ALM_OFF: sets ALARM_DONE.
  - ALARM_REQ falls: ALARM_DONE is not set.
- ALARM_DONE clears when ALARM_REQ=0.
- STOP outside the alarm states is ignored.
- Simultaneous STOP and a rising ALARM_REQ in the same cycle: STOP is ignored and the alarm starts.
- PIEZO toggles every half-period in BEEP, CHIME and ALM_ON, and is 0 in IDLE and ALM_OFF.

## Timing
- Reset values: PIEZO=0, GRANT=000, ALARM_DONE=0, state IDLE, all pending bits, duration counter and burst_cnt at 0.
- All outputs are registered.
- Request to GRANT latency: a request sampled at edge n sets GRANT at edge n+1. PIEZO first rises at edge n+1+HALF.
- Duration counter clears on state entry and counts MS_TICK pulses. The exit transition happens on the edge that samples the Nth pulse.
- Tone phase restarts, with PIEZO=0, on every state entry.
- A half-period counter that reaches HALF-1 wraps to 0 and toggles PIEZO.

## Structure
- Shared package: state encoding and GRANT one-hot constants (GNT_ALARM=3'b100, GNT_CHIME=3'b010, GNT_BEEP=3'b001).
- Sub-module tone_gen: CLK, RESETN, EN, HALF[15:0] in; PIEZO out.
  - EN low forces PIEZO=0 and clears the counter.
  - The arbiter muxes HALF by state.
  - The counter also clears when the arbiter pulses a restart on state entry, so phase restarts per the Timing rule.

## Test plan
- BEEP_REQ pulse from idle: GRANT=001 for 50 MS_TICKs, PIEZO period 25000 CLK, then GRANT=000 and PIEZO=0.
- BEEP_REQ while CHIME active: chime completes its 300 ticks, then the beep runs for 50 ticks.
- CHIME active and ALARM_REQ rises: GRANT goes to 100 on the next CLK; the chime is not replayed after ALARM_REQ falls.
- ALARM_REQ held high with ALARM_BURSTS=3: three on/off pairs of 500 ticks each, then ALARM_DONE=1 and GRANT=000. ALARM_DONE drops when ALARM_REQ falls.
- STOP during ALM_ON: the next CLK gives GRANT=000, PIEZO=0, ALARM_DONE=1. A BEEP_REQ received during the alarm is not played.
- RESETN low mid-ALM_ON: all outputs return to reset values on the next edge. After release with ALARM_REQ still high, the alarm restarts at burst 0.
